btn_cmd_arbiter: RTL and testbench

Collects the debounced, active-low button lines of the Tamagotchi front panel and classifies each press as short or long. It arbitrates pending presses round-robin and presents one command at a time to the game FSM over a valid/ready handshake. After each accepted command a cooldown interval must elapse before the next command is offered. It sits between the per-button debouncers and the main game/state controller.

---
 rtl/btn_cmd_arbiter.sv | 171 +++++++++++++++++
 tb/tb_btn_cmd_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cmd_arbiter.sv
// Front-panel button collector: classifies presses as short/long, arbitrates
// pending presses round-robin and offers one command at a time to the game FSM.
module btn_cmd_arbiter #(
  parameter int N_BTN           = 4,
  parameter int HOLD_CYCLES     = 150000000,
  parameter int COOLDOWN_CYCLES = 5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_BTN-1:0]           btn_n,
  input  logic                       enable,
  input  logic                       cmd_ready,
  output logic                       cmd_valid,
  output logic [$clog2(N_BTN)-1:0]   cmd_id,
  output logic                       cmd_long,
  output logic                       busy,
  output logic                       overrun,
  output logic [1:0]                 fsm_state
);

  localparam int ID_W   = $clog2(N_BTN);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int CD_W   = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_OFFER    = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N_BTN-1:0]  s_meta, s_sync, s_prev;
  logic [HOLD_W-1:0] hold_cnt [N_BTN];
  logic [N_BTN-1:0]  long_done, pend_short, pend_long;
  logic [N_BTN-1:0]  press, release_ev, set_short, set_long, clr_short, clr_long;
  logic [ID_W-1:0]   rr;
  logic [CD_W-1:0]   cd_cnt;
  logic              grant_vld, grant_is_long;
  logic [ID_W-1:0]   grant_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_meta <= '1;
      s_sync <= '1;
      s_prev <= '1;
    end else begin
      s_meta <= btn_n;
      s_sync <= s_meta;
      s_prev <= s_sync;
    end
  end

  // A long event fires once per hold; long_done suppresses the short event on release.
  always_comb begin
    press      = s_prev & ~s_sync;
    release_ev = ~s_prev & s_sync;
    set_short  = '0;
    set_long   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      set_short[i] = enable && release_ev[i] && !long_done[i];
      set_long[i]  = enable && !s_sync[i] && !press[i] && !long_done[i] &&
                     (hold_cnt[i] == HOLD_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) hold_cnt[i] <= '0;
      long_done <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!enable) begin
          hold_cnt[i] <= '0;
        end else if (press[i]) begin
          hold_cnt[i]  <= '0;
          long_done[i] <= 1'b0;
        end else if (!s_sync[i]) begin
          if (hold_cnt[i] != HOLD_MAX) hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
          if (set_long[i]) long_done[i] <= 1'b1;
        end
      end
    end
  end

  // Round-robin search from rr; long outranks short within the granted button.
  always_comb begin
    int idx;
    logic [N_BTN-1:0] pend_any;
    idx           = 0;
    pend_any      = pend_long | pend_short;
    grant_vld     = 1'b0;
    grant_idx     = '0;
    grant_is_long = 1'b0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!grant_vld && pend_any[idx]) begin
        grant_vld     = 1'b1;
        grant_idx     = ID_W'(idx);
        grant_is_long = pend_long[idx];
      end
    end
    grant_vld = grant_vld && enable && (state == S_IDLE);
    clr_short = '0;
    clr_long  = '0;
    if (grant_vld) begin
      if (grant_is_long) clr_long[grant_idx]  = 1'b1;
      else               clr_short[grant_idx] = 1'b1;
    end
  end

  // A new event on an already-pending bit is dropped; a same-cycle set beats the grant clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_short <= '0;
      pend_long  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (!enable) begin
        pend_short <= '0;
        pend_long  <= '0;
      end else begin
        pend_short <= (pend_short & ~clr_short) | set_short;
        pend_long  <= (pend_long & ~clr_long) | set_long;
      end
      if (|(set_short & pend_short) || |(set_long & pend_long)) overrun <= 1'b1;
    end
  end

  // Handshake: a command transfers on a cycle where cmd_valid and cmd_ready are both high;
  // once cmd_valid rises, it and cmd_id/cmd_long hold until that transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (grant_vld) state_nxt = S_OFFER;
      S_OFFER:    if (cmd_ready) state_nxt = S_COOLDOWN;
      S_COOLDOWN: if (COOLDOWN_CYCLES == 0 || cd_cnt == CD_LAST) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cmd_id   <= '0;
      cmd_long <= 1'b0;
      rr       <= '0;
      cd_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        cmd_id   <= grant_idx;
        cmd_long <= grant_is_long;
        rr       <= (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (state == S_OFFER)
        cd_cnt <= '0;
      else if (state == S_COOLDOWN && cd_cnt != CD_LAST)
        cd_cnt <= cd_cnt + CD_W'(1);
    end
  end

  assign cmd_valid = (state == S_OFFER);
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Self-checking bench for btn_cmd_arbiter: vector table, directed corner
// sequences and randomized presses against a command-order reference model.
module tb_btn_cmd_arbiter;
  localparam int N_BTN = 4;
  localparam int HOLD  = 20;
  localparam int COOL  = 5;
  localparam int ID_W  = 2;
  localparam int W     = ID_W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_BTN-1:0] btn_n = '1;
  logic             enable = 1'b1;
  logic             cmd_ready = 1'b1;
  logic             cmd_valid, cmd_long, busy, overrun;
  logic [ID_W-1:0]  cmd_id;
  logic [1:0]       fsm_state;

  btn_cmd_arbiter #(.N_BTN(N_BTN), .HOLD_CYCLES(HOLD), .COOLDOWN_CYCLES(COOL)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .enable(enable), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_long(cmd_long), .busy(busy),
    .overrun(overrun), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd       = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: record every transfer (inputs change at posedge+1, so negedge is stable)
  always @(negedge clk) begin
    if (rst && cmd_valid && cmd_ready) begin
      got_q.push_back({cmd_id, cmd_long});
      acc_cyc.push_back(cyc);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / checker tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    btn_n = '1;
    enable = 1'b1;
    cmd_ready = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(3);
  endtask

  task automatic press(input int b, input int len);
    btn_n[b] = 1'b0;
    tick(len);
    btn_n[b] = 1'b1;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!cmd_valid && lat < 80) begin
      tick(1);
      lat++;
    end
    check({name, "_valid"}, 32'(cmd_valid), 1);
  endtask

  task automatic settle(input int budget, input bit rnd_ready, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
      tick(1);
      n++;
      if (!busy && !cmd_valid && (got_q.size() - rd) >= exp_q.size()) done = 1'b1;
    end
    cmd_ready = 1'b1;
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic drain_check(input string name);
    logic [W-1:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd < got_q.size()) begin
        g = got_q[rd];
        rd++;
        check({name, "_id"}, 32'(g[W-1:1]), 32'(e[W-1:1]));
        check({name, "_long"}, 32'(g[0]), 32'(e[0]));
      end else begin
        check({name, "_missing"}, 0, 1);
      end
    end
    check({name, "_extra"}, 32'(got_q.size() - rd), 0);
    rd = got_q.size();
  endtask

  typedef struct {
    int btn;
    int len;
    int exp_id;
    bit exp_long;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, n, base, a0, a1, rr_m, nb, a, b, len, k, best;
    bit lng;
    int btns[$];

    vecs[0] = '{1, 8, 1, 1'b0};
    vecs[1] = '{2, 40, 2, 1'b1};
    vecs[2] = '{0, HOLD, 0, 1'b0};
    vecs[3] = '{3, HOLD + 1, 3, 1'b1};
    vecs[4] = '{1, 1, 1, 1'b0};

    // reset values while rst is held low
    rst = 1'b0;
    tick(2);
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_id", 32'(cmd_id), 0);
    check("rst_long", 32'(cmd_long), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b1;
    tick(3);

    // table: single presses incl. the short/long threshold on both sides
    for (int v = 0; v < 5; v++) begin
      base = got_q.size();
      btn_n[vecs[v].btn] = 1'b0;
      tick(vecs[v].len);
      if (vecs[v].exp_long && vecs[v].len >= HOLD + 8)
        check("long_while_held", 32'(got_q.size() - base), 1);
      btn_n[vecs[v].btn] = 1'b1;
      if (!vecs[v].exp_long) begin
        wait_valid("short", lat);
        check("short_latency", 32'(lat), 4);
        n = 0;
        while (busy && n < 40) begin
          n++;
          tick(1);
        end
        check("busy_len", 32'(n), 1 + COOL);
      end
      exp_q.push_back({ID_W'(vecs[v].exp_id), vecs[v].exp_long});
      settle(300, 1'b0, "vec");
      tick(12);
      drain_check("vec");
    end

    // simultaneous releases with rr = 0
    reset_dut();
    btn_n[0] = 1'b0;
    btn_n[3] = 1'b0;
    tick(8);
    btn_n = '1;
    exp_q.push_back({2'd0, 1'b0});
    exp_q.push_back({2'd3, 1'b0});
    settle(300, 1'b0, "simul");
    tick(12);
    if (acc_cyc.size() >= rd + 2) begin
      a0 = acc_cyc[rd];
      a1 = acc_cyc[rd + 1];
      check("simul_gap_ok", 32'((a1 - a0) >= COOL + 2), 1);
    end else begin
      check("simul_two_cmds", 32'(acc_cyc.size() - rd), 2);
    end
    drain_check("simul");

    // backpressure: payload stable while stalled
    cmd_ready = 1'b0;
    press(2, 6);
    wait_valid("bp", lat);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_valid", 32'(cmd_valid), 1);
      check("bp_id", 32'(cmd_id), 2);
      check("bp_long", 32'(cmd_long), 0);
    end
    cmd_ready = 1'b1;
    tick(1);
    check("bp_accept", 32'(cmd_valid), 0);
    exp_q.push_back({2'd2, 1'b0});
    settle(300, 1'b0, "bp");
    tick(12);
    drain_check("bp");

    // overrun: two btn1 presses while btn0 offer is stalled
    reset_dut();
    check("ovr_clear", 32'(overrun), 0);
    cmd_ready = 1'b0;
    press(0, 5);
    wait_valid("ovr", lat);
    press(1, 4);
    tick(4);
    check("ovr_single", 32'(overrun), 0);
    press(1, 4);
    tick(6);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_hold_id", 32'(cmd_id), 0);
    cmd_ready = 1'b1;
    exp_q.push_back({2'd0, 1'b0});
    exp_q.push_back({2'd1, 1'b0});
    settle(400, 1'b0, "ovr");
    tick(12);
    drain_check("ovr");
    check("ovr_sticky", 32'(overrun), 1);

    // enable low: press is not recorded
    reset_dut();
    enable = 1'b0;
    press(3, 6);
    tick(10);
    enable = 1'b1;
    tick(30);
    check("en_busy", 32'(busy), 0);
    drain_check("en");

    // reset during a stalled offer
    cmd_ready = 1'b0;
    press(1, 6);
    wait_valid("rmid", lat);
    press(2, 4);
    tick(4);
    press(2, 4);
    tick(6);
    check("rmid_ovr", 32'(overrun), 1);
    rst = 1'b0;
    #1;
    check("rmid_valid", 32'(cmd_valid), 0);
    check("rmid_id", 32'(cmd_id), 0);
    check("rmid_long", 32'(cmd_long), 0);
    check("rmid_busy", 32'(busy), 0);
    check("rmid_overrun", 32'(overrun), 0);
    tick(2);
    rst = 1'b1;
    cmd_ready = 1'b1;
    tick(30);
    drain_check("rmid");

    // randomized presses vs. classification + round-robin order model
    reset_dut();
    rr_m = 0;
    for (int it = 0; it < 16; it++) begin
      nb  = $urandom_range(1, 2);
      a   = $urandom_range(0, N_BTN - 1);
      b   = (a + $urandom_range(1, N_BTN - 1)) % N_BTN;
      len = $urandom_range(1, HOLD + 10);
      lng = (len > HOLD);
      btns.delete();
      btns.push_back(a);
      if (nb == 2) btns.push_back(b);
      foreach (btns[j]) btn_n[btns[j]] = 1'b0;
      tick(len);
      btn_n = '1;
      while (btns.size() > 0) begin
        best = 0;
        for (int j = 1; j < btns.size(); j++)
          if (((btns[j] - rr_m + N_BTN) % N_BTN) < ((btns[best] - rr_m + N_BTN) % N_BTN))
            best = j;
        k = btns[best];
        exp_q.push_back({ID_W'(k), lng});
        rr_m = (k + 1) % N_BTN;
        btns.delete(best);
      end
      settle(1500, 1'b1, "rand");
      tick(12);
      drain_check("rand");
      tick($urandom_range(0, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
